// File: rtl/sort4_ctrl.sv
// Four-operand bubble sorter sharing one 4-bit magnitude comparator, one compare-and-swap per clock.
// Optional early exit on a swap-free pass is enabled by defining SORT4_EARLY_EXIT_EN.
module sort4_ctrl #(
  parameter bit DESCENDING = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        busy,
  output logic [2:0]  swap_cnt
);

  typedef enum logic [1:0] {StIdle, StSort, StDone} state_e;

  state_e     state;
  logic [3:0] r [4];
  logic [1:0] pass;
  logic [1:0] pair;

  // Shared comparator: a = r[pair], b = r[pair+1]
  logic [3:0] cmp_a, cmp_b;
  logic       agtb, altb;
  logic       do_swap;
  logic       last_pair;
  logic       sort_end;

  assign cmp_a = r[pair];
  assign cmp_b = r[pair + 2'd1];
  assign agtb  = cmp_a > cmp_b;
  assign altb  = cmp_a < cmp_b;

  // Equal operands never swap, which keeps the sort stable.
  assign do_swap   = DESCENDING ? altb : agtb;
  assign last_pair = (pair == (2'd3 - pass));

`ifdef SORT4_EARLY_EXIT_EN
  logic pass_swapped;
  assign sort_end = last_pair && ((pass == 2'd3) || !(pass_swapped || do_swap));
`else
  assign sort_end = last_pair && (pass == 2'd3);
`endif

  assign in_ready = (state == StIdle);
  assign busy     = (state != StIdle);
  assign out_data = {r[3], r[2], r[1], r[0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      for (int i = 0; i < 4; i++) r[i] <= 4'd0;
      pass      <= 2'd0;
      pair      <= 2'd0;
      swap_cnt  <= 3'd0;
      out_valid <= 1'b0;
`ifdef SORT4_EARLY_EXIT_EN
      pass_swapped <= 1'b0;
`endif
    end else begin
      case (state)
        StIdle: begin
          if (in_valid) begin
            r[0]     <= in_data[3:0];
            r[1]     <= in_data[7:4];
            r[2]     <= in_data[11:8];
            r[3]     <= in_data[15:12];
            swap_cnt <= 3'd0;
            pass     <= 2'd1;
            pair     <= 2'd0;
            state    <= StSort;
`ifdef SORT4_EARLY_EXIT_EN
            pass_swapped <= 1'b0;
`endif
          end
        end
        StSort: begin
          if (do_swap) begin
            r[pair]         <= cmp_b;
            r[pair + 2'd1]  <= cmp_a;
            swap_cnt        <= swap_cnt + 3'd1;
          end
          if (sort_end) begin
            state     <= StDone;
            out_valid <= 1'b1;
          end else if (last_pair) begin
            pass <= pass + 2'd1;
            pair <= 2'd0;
`ifdef SORT4_EARLY_EXIT_EN
            pass_swapped <= 1'b0;
`endif
          end else begin
            pair <= pair + 2'd1;
`ifdef SORT4_EARLY_EXIT_EN
            if (do_swap) pass_swapped <= 1'b1;
`endif
          end
        end
        StDone: begin
          if (out_ready) begin
            state     <= StIdle;
            out_valid <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sort4_ctrl.sv
// Scoreboard bench for sort4_ctrl: an ascending and a descending instance, reference-model checked.
module tb_sort4_ctrl;

`ifdef SORT4_EARLY_EXIT_EN
  localparam bit Early = 1'b1;
`else
  localparam bit Early = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid [2];
  logic        in_ready [2];
  logic [15:0] in_data  [2];
  logic        out_valid[2];
  logic        out_ready[2];
  logic [15:0] out_data [2];
  logic        busy     [2];
  logic [2:0]  swap_cnt [2];

  sort4_ctrl #(.DESCENDING(1'b0)) dut_asc (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .busy(busy[0]), .swap_cnt(swap_cnt[0])
  );

  sort4_ctrl #(.DESCENDING(1'b1)) dut_desc (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .busy(busy[1]), .swap_cnt(swap_cnt[1])
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    int          sw;
    int          lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   acc_cyc [2];
  bit   lat_done[2];
  int   rdy_mode[2];  // 0 random, 1 hold low, 2 hold high

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Plain bubble sort over an int array; counts compares to get the latency.
  function automatic exp_t model(input logic [15:0] d, input bit desc);
    exp_t e;
    int   v[4];
    int   c = 0;
    bit   stop = 1'b0;
    e.sw = 0;
    for (int i = 0; i < 4; i++) v[i] = int'(d[4*i +: 4]);
    for (int p = 1; p <= 3 && !stop; p++) begin
      int ps = 0;
      for (int j = 0; j < 4 - p; j++) begin
        c++;
        if (desc ? (v[j] < v[j+1]) : (v[j] > v[j+1])) begin
          int t = v[j];
          v[j]   = v[j+1];
          v[j+1] = t;
          ps++;
          e.sw++;
        end
      end
      if (Early && ps == 0) stop = 1'b1;
    end
    e.lat = c + 1;
    e.d = {4'(v[3]), 4'(v[2]), 4'(v[1]), 4'(v[0])};
    return e;
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++)
      out_ready[k] = (rdy_mode[k] == 0) ? 1'($urandom_range(0, 1)) : (rdy_mode[k] == 2);
  end

  // Monitor: pops the scoreboard on each output handshake and checks hold/latency.
  always @(posedge clk) begin
    bit          fin [2];
    bit          fout[2];
    bit          hold[2];
    logic [15:0] sd  [2];
    logic [2:0]  ss  [2];
    exp_t        e;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      fin[k]  = !rst && in_valid[k] && in_ready[k];
      fout[k] = !rst && out_valid[k] && out_ready[k];
      hold[k] = !rst && out_valid[k] && !out_ready[k];
      sd[k]   = out_data[k];
      ss[k]   = swap_cnt[k];
      if (fin[k]) begin
        acc_cyc[k]  = cyc;
        lat_done[k] = 1'b0;
      end
      if (fout[k]) begin
        if (qsize(k) == 0) chk("unexpected_output", 1, 0);
        else begin
          e = (k == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("out_data[%0d]", k), int'(sd[k]), int'(e.d));
          chk($sformatf("swap_cnt[%0d]", k), int'(ss[k]), e.sw);
        end
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      if (hold[k] && !rst) begin
        chk($sformatf("hold_data[%0d]", k), int'(out_data[k]), int'(sd[k]));
        chk($sformatf("hold_swaps[%0d]", k), int'(swap_cnt[k]), int'(ss[k]));
        chk($sformatf("hold_valid[%0d]", k), int'(out_valid[k]), 1);
      end
      if (out_valid[k] && !lat_done[k]) begin
        lat_done[k] = 1'b1;
        if (qsize(k) > 0) begin
          e = (k == 0) ? q0[0] : q1[0];
          chk($sformatf("latency[%0d]", k), cyc - acc_cyc[k] + 1, e.lat);
        end
      end
    end
  end

  task automatic send(input int k, input logic [15:0] d);
    int t = 0;
    @(negedge clk);
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    while (!in_ready[k] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready[k]) chk("accept_timeout", 0, 1);
    else if (k == 0) q0.push_back(model(d, 1'b0));
    else q1.push_back(model(d, 1'b1));
    @(negedge clk);
    in_valid[k] = 1'b0;
    in_data[k]  = 16'($urandom);
  endtask

  task automatic wait_empty(input int k);
    int t = 0;
    while (qsize(k) > 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (qsize(k) > 0) begin
      chk("drain_timeout", qsize(k), 0);
      if (k == 0) q0.delete(); else q1.delete();
    end
  endtask

  task automatic chk_reset(input int k);
    chk($sformatf("rst_out_valid[%0d]", k), int'(out_valid[k]), 0);
    chk($sformatf("rst_busy[%0d]", k), int'(busy[k]), 0);
    chk($sformatf("rst_swap_cnt[%0d]", k), int'(swap_cnt[k]), 0);
    chk($sformatf("rst_out_data[%0d]", k), int'(out_data[k]), 0);
    chk($sformatf("rst_in_ready[%0d]", k), int'(in_ready[k]), 1);
  endtask

  initial begin
    int t;
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0;
      in_data[k]  = 16'h0;
      rdy_mode[k] = 2;
      lat_done[k] = 1'b1;
      acc_cyc[k]  = 0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    rst = 1'b0;

    // Directed vectors
    send(0, 16'h1234);
    send(0, 16'h4321);
    send(0, 16'h5A5A);
    send(1, 16'h4321);
    send(1, 16'h1234);
    wait_empty(0);
    wait_empty(1);

    // Output backpressure
    rdy_mode[0] = 1;
    send(0, 16'h2713);
    t = 0;
    while (!out_valid[0] && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("bp_valid_seen", int'(out_valid[0]), 1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", int'(in_ready[0]), 0);
      chk("bp_out_valid", int'(out_valid[0]), 1);
    end
    rdy_mode[0] = 2;
    t = 0;
    while (out_valid[0] && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("bp_release_in_ready", int'(in_ready[0]), 1);
    send(0, 16'hF0A3);
    wait_empty(0);

    // Reset during the third compare cycle
    send(0, 16'h1234);
    repeat (2) @(negedge clk);
    chk("mid_sort_swaps", int'(swap_cnt[0]), 2);
    rst = 1'b1;
    #1;
    chk_reset(0);
    q0.delete();
    lat_done[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send(0, 16'h1234);
    wait_empty(0);

    // Randomized traffic with random consumer stalls
    rdy_mode[0] = 0;
    rdy_mode[1] = 0;
    for (int i = 0; i < 40; i++) send(i % 2, 16'($urandom));
    wait_empty(0);
    wait_empty(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
